ft_lockstep_checker: RTL
========================

// Module: ft_lockstep_checker
// PURPOSE
// Sits between the two redundant cores and the shared instruction and data memories.
// Compares both cores' bus requests every cycle and forwards core 0's request only when they agree.
// On divergence: blocks the request, flags the error, stalls both cores and pulses a recovery
// request to the register-restore logic. Repeated divergence escalates to a sticky fail state.
// PARAMETERS
// ADDR_W        32  address width of instr/data buses
// DATA_W        32  data bus width
// RECOVER_CYC    4  cycles halt_o stays high in RECOVER (>=1)
// MAX_RETRY      3  mismatches, without CLEAR_CYC clean RUN cycles between them, that cause FAIL
// CLEAR_CYC     16  consecutive clean RUN cycles that reset the retry counter
// PORTS
// clk_i          in   1         clock
// rst_ni         in   1         asynchronous active-low reset
// c0_instr_req_i in   1         core 0 fetch request (c1_* is the identical set for core 1)
// c0_instr_addr_i in  ADDR_W    core 0 fetch address
// c0_data_req_i  in   1         core 0 data request
// c0_data_we_i   in   1         core 0 write enable
// c0_data_be_i   in   DATA_W/8  core 0 byte enables
// c0_data_addr_i in   ADDR_W    core 0 data address
// c0_data_wdata_i in  DATA_W    core 0 write data
// c1_*           in   as c0_*   core 1 request set
// instr_req_o    out  1         forwarded fetch request
// instr_addr_o   out  ADDR_W    forwarded fetch address (core 0's value)
// data_req_o     out  1         forwarded data request
// data_we_o/be_o/addr_o/wdata_o  out  as inputs   forwarded core 0 data fields
// halt_o         out  1         stall/clock-gate request to both cores
// recover_o      out  1         1-cycle pulse: restore core state from checkpoint
// error_o        out  1         1-cycle pulse on each detected mismatch
// fail_o         out  1         sticky unrecoverable-fault flag
// err_count_o    out  8         saturating total mismatch count
// BEHAVIOUR
// Reset (rst_ni=0, async): state=RUN; all outputs 0; retry_cnt=0, clean_cnt=0, err_count_o=0.
// Match, evaluated combinationally each cycle:
//  - instr fields: req bits equal; if either req=1, addrs equal.
//  - data fields: req bits equal; if either req=1, we and addr equal; if we=1, be and wdata
//    equal. wdata is compared only on bytes where be=1.
//  - mismatch = !match. Bus fields whose req is 0 on both cores are don't-care.
// RUN:
//  - match: *_req_o = c0 reqs; other fields = c0 values (0-cycle latency); clean_cnt++,
//    saturating at CLEAR_CYC; on reaching CLEAR_CYC, retry_cnt<=0.
//  - mismatch: both *_req_o forced 0 in that same cycle (no corrupted write reaches memory);
//    error_o=1; err_count_o++ (saturates at 255); clean_cnt<=0; retry_cnt++.
//    If new retry_cnt==MAX_RETRY -> FAIL, else -> RECOVER.
// RECOVER:
//  - halt_o=1 throughout; recover_o=1 on the first cycle only; *_req_o=0.
//  - stays RECOVER_CYC cycles, then -> RUN; mismatches are ignored while in RECOVER.
// FAIL: halt_o=1, fail_o=1, *_req_o=0, no further error_o; left only by reset.
// error_o and recover_o are registered: each asserts one cycle after its triggering event.
//  Gating of *_req_o is combinational.
// Reset mid-RECOVER or mid-FAIL returns to RUN with all counters cleared.
// err_count_o is not cleared by recovery; only reset clears it.
// TESTING
// 1 Identical fibonacci-style request streams for 200 cycles -> outputs mirror core 0;
//   error_o, halt_o and fail_o stay 0; err_count_o=0.
// 2 c1_data_wdata differs for 1 cycle with we=1, be=4'hF -> data_req_o=0 that cycle;
//   error_o pulse next cycle; halt_o high 4 cycles; one recover_o pulse; err_count_o=1; back to RUN.
// 3 wdata differs only in byte 3 with be=4'h1 -> no mismatch, request forwarded.
// 4 Three mismatches, each separated by fewer than 16 clean cycles -> fail_o=1 after the third;
//   halt_o stays high; later mismatches leave err_count_o=3.
// 5 Two mismatches separated by 20 clean cycles, then a third -> no FAIL (retry reset); err_count_o=3.
// 6 rst_ni dropped on cycle 2 of RECOVER -> all outputs 0 immediately; after release,
//   clean traffic is forwarded.

Source files
------------

// File: rtl/ft_lockstep_checker.sv
// Dual-core lockstep bus checker: forwards core 0's instruction/data requests while both cores agree,
// otherwise blocks the request, stalls both cores, requests a checkpoint restore and escalates to a sticky FAIL.
module ft_lockstep_checker #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RECOVER_CYC = 4,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CLEAR_CYC   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                c0_instr_req_i,
    input  logic [ADDR_W-1:0]   c0_instr_addr_i,
    input  logic                c0_data_req_i,
    input  logic                c0_data_we_i,
    input  logic [DATA_W/8-1:0] c0_data_be_i,
    input  logic [ADDR_W-1:0]   c0_data_addr_i,
    input  logic [DATA_W-1:0]   c0_data_wdata_i,
    input  logic                c1_instr_req_i,
    input  logic [ADDR_W-1:0]   c1_instr_addr_i,
    input  logic                c1_data_req_i,
    input  logic                c1_data_we_i,
    input  logic [DATA_W/8-1:0] c1_data_be_i,
    input  logic [ADDR_W-1:0]   c1_data_addr_i,
    input  logic [DATA_W-1:0]   c1_data_wdata_i,
    output logic                instr_req_o,
    output logic [ADDR_W-1:0]   instr_addr_o,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    output logic                halt_o,
    output logic                recover_o,
    output logic                error_o,
    output logic                fail_o,
    output logic [7:0]          err_count_o
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned RC_W = $clog2(RECOVER_CYC + 1);
    localparam int unsigned RT_W = $clog2(MAX_RETRY + 1);
    localparam int unsigned CL_W = $clog2(CLEAR_CYC + 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RECOVER_CYC - 1);
    localparam logic [RT_W-1:0] RETRY_MAX = RT_W'(MAX_RETRY);
    localparam logic [CL_W-1:0] CLEAN_MAX = CL_W'(CLEAR_CYC);

    typedef enum logic [1:0] {ST_RUN, ST_RECOVER, ST_FAIL} state_e;

    state_e          state_q, state_d;
    logic [RC_W-1:0] rec_cnt_q, rec_cnt_d;
    logic [RT_W-1:0] retry_q, retry_d;
    logic [CL_W-1:0] clean_q, clean_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            error_q, error_d;
    logic            recover_q, recover_d;

    logic instr_ok, wdata_ok, data_ok, match, fwd;

    always_comb begin
        instr_ok = (c0_instr_req_i == c1_instr_req_i) &&
                   (!c0_instr_req_i || (c0_instr_addr_i == c1_instr_addr_i));
        // Only bytes enabled for the write take part in the data comparison.
        wdata_ok = 1'b1;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (c0_data_be_i[b] && (c0_data_wdata_i[8*b +: 8] != c1_data_wdata_i[8*b +: 8])) begin
                wdata_ok = 1'b0;
            end
        end
        data_ok = (c0_data_req_i == c1_data_req_i) &&
                  (!c0_data_req_i ||
                   ((c0_data_we_i == c1_data_we_i) && (c0_data_addr_i == c1_data_addr_i) &&
                    (!c0_data_we_i || ((c0_data_be_i == c1_data_be_i) && wdata_ok))));
        match = instr_ok && data_ok;
        fwd   = rst_ni && (state_q == ST_RUN) && match;
    end

    always_comb begin
        instr_req_o  = fwd & c0_instr_req_i;
        instr_addr_o = fwd ? c0_instr_addr_i : '0;
        data_req_o   = fwd & c0_data_req_i;
        data_we_o    = fwd & c0_data_we_i;
        data_be_o    = fwd ? c0_data_be_i : '0;
        data_addr_o  = fwd ? c0_data_addr_i : '0;
        data_wdata_o = fwd ? c0_data_wdata_i : '0;
        halt_o       = (state_q != ST_RUN);
        fail_o       = (state_q == ST_FAIL);
        error_o      = error_q;
        recover_o    = recover_q;
        err_count_o  = err_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        rec_cnt_d = rec_cnt_q;
        retry_d   = retry_q;
        clean_d   = clean_q;
        err_cnt_d = err_cnt_q;
        error_d   = 1'b0;
        recover_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (match) begin
                    if (clean_q != CLEAN_MAX) clean_d = clean_q + 1'b1;
                    if (clean_d == CLEAN_MAX) retry_d = '0;
                end else begin
                    error_d   = 1'b1;
                    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                    clean_d   = '0;
                    retry_d   = retry_q + 1'b1;
                    rec_cnt_d = '0;
                    if (retry_d == RETRY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d   = ST_RECOVER;
                        recover_d = 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q == RC_LAST) state_d = ST_RUN;
                else                      rec_cnt_d = rec_cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            rec_cnt_q <= '0;
            retry_q   <= '0;
            clean_q   <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
            recover_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
            retry_q   <= retry_d;
            clean_q   <= clean_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
            recover_q <= recover_d;
        end
    end

endmodule
